// File: rtl/phys_reg_free_list_pkg.sv
// Shared constants and types for the physical register file, ready table, rename and free list.
package phys_reg_free_list_pkg;

    localparam int unsigned NUM_PHYS = 64;
    localparam int unsigned NUM_ARCH = 32;
    localparam int unsigned LANES    = 4;
    localparam int unsigned TAG_W    = 6;
    localparam int unsigned DEPTH    = NUM_PHYS - NUM_ARCH;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned PTR_W    = IDX_W + 1;

    typedef logic [TAG_W-1:0] phys_tag_t;
    typedef logic [LANES-1:0] lane_mask_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [2:0]       lane_cnt_t;

    function automatic logic [IDX_W-1:0] ptr_idx(ptr_t p);
        return p[IDX_W-1:0];
    endfunction

    // Mask with the low c lanes set.
    function automatic lane_mask_t cnt_to_mask(lane_cnt_t c);
        lane_mask_t m;
        m = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (i < int'(c)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit-side bundle of the physical register free list.
interface phys_reg_free_list_if;
    import phys_reg_free_list_pkg::*;

    logic       takeReq;
    lane_cnt_t  takeCount;
    logic       takeAck;
    phys_tag_t  takeTag0;
    phys_tag_t  takeTag1;
    phys_tag_t  takeTag2;
    phys_tag_t  takeTag3;
    lane_mask_t clrEn;
    logic       commitEn;
    lane_cnt_t  commitTakeCount;
    lane_mask_t relEn;
    phys_tag_t  relTag0;
    phys_tag_t  relTag1;
    phys_tag_t  relTag2;
    phys_tag_t  relTag3;
    logic       flush;
    ptr_t       freeCount;
    logic       errFlag;

    modport master (
        output takeReq, takeCount, commitEn, commitTakeCount, relEn,
               relTag0, relTag1, relTag2, relTag3, flush,
        input  takeAck, takeTag0, takeTag1, takeTag2, takeTag3, clrEn, freeCount, errFlag
    );

    modport slave (
        input  takeReq, takeCount, commitEn, commitTakeCount, relEn,
               relTag0, relTag1, relTag2, relTag3, flush,
        output takeAck, takeTag0, takeTag1, takeTag2, takeTag3, clrEn, freeCount, errFlag
    );

endinterface

// File: rtl/phys_reg_free_list_release_packer.sv
// Compacts enabled release lanes into a dense ascending list, dropping tag 0.
module phys_reg_free_list_release_packer
    import phys_reg_free_list_pkg::*;
(
    input  lane_mask_t rel_en_i,
    input  phys_tag_t  rel_tag_i  [LANES],
    output phys_tag_t  pack_tag_o [LANES],
    output lane_cnt_t  rel_cnt_o
);

    lane_cnt_t cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < int'(LANES); i++) pack_tag_o[i] = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (rel_en_i[i] && (rel_tag_i[i] != '0)) begin
                pack_tag_o[cnt[1:0]] = rel_tag_i[i];
                cnt = cnt + 3'd1;
            end
        end
        rel_cnt_o = cnt;
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with speculative/committed read pointers.
// Optional sanity checking (errFlag) is built when FREELIST_CHECK_EN is defined.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input logic             clk,
    input logic             reset,
    phys_reg_free_list_if.slave fl
);

    phys_tag_t  mem_q [DEPTH];
    phys_tag_t  mem_d [DEPTH];
    ptr_t       rd_ptr_q, rd_ptr_d;
    ptr_t       rd_ptr_c_q, rd_ptr_c_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       free_count_q, free_count_d;
    logic       take_ack_q, take_ack_d;
    phys_tag_t  take_tag_q [LANES];
    phys_tag_t  take_tag_d [LANES];
    lane_mask_t clr_en_q, clr_en_d;

    phys_tag_t  rel_tag [LANES];
    phys_tag_t  rel_pack [LANES];
    lane_cnt_t  rel_cnt;
    lane_cnt_t  take_cnt;
    ptr_t       free_cur;
    logic       grant;

    assign rel_tag[0] = fl.relTag0;
    assign rel_tag[1] = fl.relTag1;
    assign rel_tag[2] = fl.relTag2;
    assign rel_tag[3] = fl.relTag3;

    phys_reg_free_list_release_packer u_packer (
        .rel_en_i   (fl.relEn),
        .rel_tag_i  (rel_tag),
        .pack_tag_o (rel_pack),
        .rel_cnt_o  (rel_cnt)
    );

    assign take_cnt = (fl.takeCount > 3'd4) ? 3'd4 : fl.takeCount;
    // Grant uses the start-of-cycle count, so same-cycle releases are not visible.
    assign free_cur = wr_ptr_q - rd_ptr_q;
    assign grant    = fl.takeReq && !fl.flush && (free_cur >= {3'b000, take_cnt});

    always_comb begin
        mem_d      = mem_q;
        take_tag_d = take_tag_q;
        rd_ptr_d   = rd_ptr_q;
        rd_ptr_c_d = rd_ptr_c_q;
        wr_ptr_d   = wr_ptr_q;

        if (grant) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (i < int'(take_cnt)) take_tag_d[i] = mem_q[ptr_idx(rd_ptr_q + ptr_t'(i))];
            end
            rd_ptr_d = rd_ptr_q + {3'b000, take_cnt};
        end
        take_ack_d = grant;
        clr_en_d   = grant ? cnt_to_mask(take_cnt) : '0;

        for (int j = 0; j < int'(LANES); j++) begin
            if (j < int'(rel_cnt)) mem_d[ptr_idx(wr_ptr_q + ptr_t'(j))] = rel_pack[j];
        end
        wr_ptr_d = wr_ptr_q + {3'b000, rel_cnt};

        if (fl.commitEn) rd_ptr_c_d = rd_ptr_c_q + {3'b000, fl.commitTakeCount};
        if (fl.flush) rd_ptr_d = rd_ptr_c_d;

        free_count_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= phys_tag_t'(NUM_ARCH + i);
            for (int i = 0; i < int'(LANES); i++) take_tag_q[i] <= '0;
            rd_ptr_q     <= '0;
            rd_ptr_c_q   <= '0;
            wr_ptr_q     <= ptr_t'(DEPTH);
            free_count_q <= ptr_t'(DEPTH);
            take_ack_q   <= 1'b0;
            clr_en_q     <= '0;
        end else begin
            mem_q        <= mem_d;
            take_tag_q   <= take_tag_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_ptr_c_q   <= rd_ptr_c_d;
            wr_ptr_q     <= wr_ptr_d;
            free_count_q <= free_count_d;
            take_ack_q   <= take_ack_d;
            clr_en_q     <= clr_en_d;
        end
    end

    assign fl.takeAck   = take_ack_q;
    assign fl.takeTag0  = take_tag_q[0];
    assign fl.takeTag1  = take_tag_q[1];
    assign fl.takeTag2  = take_tag_q[2];
    assign fl.takeTag3  = take_tag_q[3];
    assign fl.clrEn     = clr_en_q;
    assign fl.freeCount = free_count_q;

`ifdef FREELIST_CHECK_EN
    logic                err_q, err_d;
    logic [NUM_PHYS-1:0] alloc_mask_q, alloc_mask_d;

    // Architectural tags count as allocated out of reset since they are mapped.
    always_comb begin
        err_d        = err_q;
        alloc_mask_d = alloc_mask_q;
        if (({1'b0, free_cur} + {4'b0000, rel_cnt}) > 7'd32) err_d = 1'b1;
        if (fl.commitEn && ((rd_ptr_q - rd_ptr_c_q) < {3'b000, fl.commitTakeCount})) err_d = 1'b1;
        for (int j = 0; j < int'(LANES); j++) begin
            if (j < int'(rel_cnt)) begin
                if ((rel_pack[j] < phys_tag_t'(NUM_ARCH)) && !alloc_mask_q[rel_pack[j]]) begin
                    err_d = 1'b1;
                end
                alloc_mask_d[rel_pack[j]] = 1'b0;
            end
        end
        if (grant) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (i < int'(take_cnt)) alloc_mask_d[take_tag_d[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q        <= 1'b0;
            alloc_mask_q <= {{(NUM_PHYS - NUM_ARCH){1'b0}}, {NUM_ARCH{1'b1}}};
        end else begin
            err_q        <= err_d;
            alloc_mask_q <= alloc_mask_d;
        end
    end

    assign fl.errFlag = err_q;
`else
    assign fl.errFlag = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed self-checking bench for phys_reg_free_list.
module tb_phys_reg_free_list;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    phys_reg_free_list_if fl_if ();

    phys_reg_free_list dut (
        .clk   (clk),
        .reset (reset),
        .fl    (fl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        fl_if.takeReq         = 1'b0;
        fl_if.takeCount       = 3'd0;
        fl_if.commitEn        = 1'b0;
        fl_if.commitTakeCount = 3'd0;
        fl_if.relEn           = 4'b0000;
        fl_if.relTag0         = 6'd0;
        fl_if.relTag1         = 6'd0;
        fl_if.relTag2         = 6'd0;
        fl_if.relTag3         = 6'd0;
        fl_if.flush           = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic take(input logic [2:0] n);
        fl_if.takeReq   = 1'b1;
        fl_if.takeCount = n;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        do_reset();
        chk("rst_ack", fl_if.takeAck, 0);
        chk("rst_clr", fl_if.clrEn, 0);
        chk("rst_fc", fl_if.freeCount, 32);
        chk("rst_tag0", fl_if.takeTag0, 0);
        chk("rst_err", fl_if.errFlag, 0);

        // First allocation of four.
        take(3'd4);
        step();
        chk("t1_ack", fl_if.takeAck, 1);
        chk("t1_tag0", fl_if.takeTag0, 32);
        chk("t1_tag1", fl_if.takeTag1, 33);
        chk("t1_tag2", fl_if.takeTag2, 34);
        chk("t1_tag3", fl_if.takeTag3, 35);
        chk("t1_clr", fl_if.clrEn, 4'b1111);
        chk("t1_fc", fl_if.freeCount, 28);

        // Drain to empty, then one refused request.
        for (int i = 0; i < 7; i++) step();
        chk("t2_ack8", fl_if.takeAck, 1);
        chk("t2_tag0_8", fl_if.takeTag0, 60);
        chk("t2_tag3_8", fl_if.takeTag3, 63);
        chk("t2_fc8", fl_if.freeCount, 0);
        step();
        chk("t2_ack9", fl_if.takeAck, 0);
        chk("t2_clr9", fl_if.clrEn, 0);
        chk("t2_fc9", fl_if.freeCount, 0);
        chk("t2_hold9", fl_if.takeTag0, 60);

        // Release 20,21 to reach 2 free, then request 3 while releasing 5,7.
        idle();
        fl_if.relEn   = 4'b0011;
        fl_if.relTag0 = 6'd20;
        fl_if.relTag1 = 6'd21;
        step();
        chk("t3_fc2", fl_if.freeCount, 2);
        take(3'd3);
        fl_if.relTag0 = 6'd5;
        fl_if.relTag1 = 6'd7;
        step();
        chk("t3_noack", fl_if.takeAck, 0);
        chk("t3_noclr", fl_if.clrEn, 0);
        chk("t3_fc4", fl_if.freeCount, 4);
        fl_if.relEn = 4'b0000;
        step();
        chk("t3_ack", fl_if.takeAck, 1);
        chk("t3_tag0", fl_if.takeTag0, 20);
        chk("t3_tag1", fl_if.takeTag1, 21);
        chk("t3_tag2", fl_if.takeTag2, 5);
        chk("t3_tag3hold", fl_if.takeTag3, 63);
        chk("t3_clr", fl_if.clrEn, 4'b0111);
        chk("t3_fc1", fl_if.freeCount, 1);

        // Allocate 8, commit 4, flush the rest back.
        do_reset();
        take(3'd4);
        step();
        step();
        chk("t4_fc24", fl_if.freeCount, 24);
        idle();
        fl_if.commitEn        = 1'b1;
        fl_if.commitTakeCount = 3'd4;
        step();
        chk("t4_fc_commit", fl_if.freeCount, 24);
        idle();
        fl_if.flush = 1'b1;
        take(3'd1);
        step();
        chk("t4_flush_ack", fl_if.takeAck, 0);
        chk("t4_flush_clr", fl_if.clrEn, 0);
        chk("t4_flush_fc", fl_if.freeCount, 28);
        fl_if.flush = 1'b0;
        take(3'd4);
        step();
        chk("t4_tag0", fl_if.takeTag0, 36);
        chk("t4_tag1", fl_if.takeTag1, 37);
        chk("t4_tag2", fl_if.takeTag2, 38);
        chk("t4_tag3", fl_if.takeTag3, 39);
        chk("t4_fc", fl_if.freeCount, 24);

        // Release with tag 0 on two lanes; only 9 and 12 enter the list.
        idle();
        fl_if.relEn   = 4'b1111;
        fl_if.relTag0 = 6'd0;
        fl_if.relTag1 = 6'd9;
        fl_if.relTag2 = 6'd0;
        fl_if.relTag3 = 6'd12;
        step();
        chk("t5_fc26", fl_if.freeCount, 26);
        idle();
        take(3'd7);
        step();
        chk("t5_clamp_clr", fl_if.clrEn, 4'b1111);
        chk("t5_clamp_tag0", fl_if.takeTag0, 40);
        chk("t5_clamp_tag3", fl_if.takeTag3, 43);
        chk("t5_clamp_fc", fl_if.freeCount, 22);
        take(3'd4);
        for (int i = 0; i < 5; i++) step();
        chk("t5_tag3_63", fl_if.takeTag3, 63);
        chk("t5_fc2", fl_if.freeCount, 2);
        take(3'd2);
        step();
        chk("t5_tag0_9", fl_if.takeTag0, 9);
        chk("t5_tag1_12", fl_if.takeTag1, 12);
        chk("t5_tag2hold", fl_if.takeTag2, 62);
        chk("t5_clr", fl_if.clrEn, 4'b0011);
        chk("t5_fc0", fl_if.freeCount, 0);
        take(3'd1);
        step();
        chk("t5_empty_ack", fl_if.takeAck, 0);
        chk("t5_empty_fc", fl_if.freeCount, 0);
        take(3'd0);
        step();
        chk("t5_zero_ack", fl_if.takeAck, 1);
        chk("t5_zero_clr", fl_if.clrEn, 0);
        chk("t5_zero_fc", fl_if.freeCount, 0);
        chk("t5_err", fl_if.errFlag, 0);

`ifdef FREELIST_CHECK_EN
        // Overflowing release at full capacity sets the sticky error.
        do_reset();
        fl_if.relEn   = 4'b0001;
        fl_if.relTag0 = 6'd40;
        step();
        chk("t6_err_set", fl_if.errFlag, 1);
        idle();
        step();
        step();
        chk("t6_err_held", fl_if.errFlag, 1);
        reset = 1'b0;
        step();
        chk("t6_err_clr", fl_if.errFlag, 0);
        reset = 1'b1;
`else
        fl_if.relEn   = 4'b0001;
        fl_if.relTag0 = 6'd40;
        idle();
        step();
        chk("t6_err_tied", fl_if.errFlag, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
